// File: rtl/register_file_2w2r.sv
// Dual-write, dual-read register file; entry 0 reads as zero.
// Optional write-to-read bypass and optional registered read outputs.
module register_file_2w2r #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WEN_A,
    input  logic [ADDR_W-1:0] RW_A,
    input  logic [DATA_W-1:0] busW_A,
    input  logic              WEN_B,
    input  logic [ADDR_W-1:0] RW_B,
    input  logic [DATA_W-1:0] busW_B,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    output logic [DATA_W-1:0] busX,
    output logic [DATA_W-1:0] busY
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [1:DEPTH-1];
    logic [DATA_W-1:0] src_x;
    logic [DATA_W-1:0] src_y;

    // Port B is applied last so it wins an address collision.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (WEN_B && RW_B == ADDR_W'(i)) begin
                    mem[i] <= busW_B;
                end else if (WEN_A && RW_A == ADDR_W'(i)) begin
                    mem[i] <= busW_A;
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_src(
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (a == ADDR_W'(i)) begin
                v = mem[i];
            end
        end
        if (BYPASS != 0 && a != '0) begin
            if (WEN_B && RW_B == a) begin
                v = busW_B;
            end else if (WEN_A && RW_A == a) begin
                v = busW_A;
            end
        end
        return v;
    endfunction

    always_comb begin
        src_x = read_src(RX);
        src_y = read_src(RY);
    end

    if (READ_REG != 0) begin : g_reg
        logic [DATA_W-1:0] x_q;
        logic [DATA_W-1:0] y_q;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                x_q <= '0;
                y_q <= '0;
            end else begin
                x_q <= src_x;
                y_q <= src_y;
            end
        end

        assign busX = x_q;
        assign busY = y_q;
    end else begin : g_comb
        assign busX = src_x;
        assign busY = src_y;
    end

endmodule

// File: tb/tb_register_file_2w2r.sv
// Bench for register_file_2w2r: four parameter sets, vector table,
// hand sequences and random traffic against an array model.
`timescale 1ns/1ps
module tb_register_file_2w2r;

    logic Clk;
    logic Rst_n;

    logic        n_wena, n_wenb;
    logic [2:0]  n_ra, n_rb, n_rx, n_ry;
    logic [7:0]  n_da, n_db;
    logic [7:0]  n0_x, n0_y, n1_x, n1_y;

    logic        w_wena, w_wenb;
    logic [3:0]  w_ra, w_rb, w_rx, w_ry;
    logic [15:0] w_da, w_db;
    logic [15:0] w2_x, w2_y, w3_x, w3_y;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_n [16];
    logic [15:0] mem_w [16];
    logic [15:0] exp2_x, exp2_y, exp3_x, exp3_y;

    register_file_2w2r #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .READ_REG(0)) u0 (
        .Clk(Clk), .Rst_n(Rst_n),
        .WEN_A(n_wena), .RW_A(n_ra), .busW_A(n_da),
        .WEN_B(n_wenb), .RW_B(n_rb), .busW_B(n_db),
        .RX(n_rx), .RY(n_ry), .busX(n0_x), .busY(n0_y)
    );

    register_file_2w2r #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .READ_REG(0)) u1 (
        .Clk(Clk), .Rst_n(Rst_n),
        .WEN_A(n_wena), .RW_A(n_ra), .busW_A(n_da),
        .WEN_B(n_wenb), .RW_B(n_rb), .busW_B(n_db),
        .RX(n_rx), .RY(n_ry), .busX(n1_x), .busY(n1_y)
    );

    register_file_2w2r #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .READ_REG(1)) u2 (
        .Clk(Clk), .Rst_n(Rst_n),
        .WEN_A(w_wena), .RW_A(w_ra), .busW_A(w_da),
        .WEN_B(w_wenb), .RW_B(w_rb), .busW_B(w_db),
        .RX(w_rx), .RY(w_ry), .busX(w2_x), .busY(w2_y)
    );

    register_file_2w2r #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .READ_REG(1)) u3 (
        .Clk(Clk), .Rst_n(Rst_n),
        .WEN_A(w_wena), .RW_A(w_ra), .busW_A(w_da),
        .WEN_B(w_wenb), .RW_B(w_rb), .busW_B(w_db),
        .RX(w_rx), .RY(w_ry), .busX(w3_x), .busY(w3_y)
    );

    initial Clk = 1'b0;
    always #20 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       wa;
        logic [2:0] ra;
        logic [7:0] da;
        logic       wb;
        logic [2:0] rb;
        logic [7:0] db;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] xb;
        logic [7:0] yb;
        logic [7:0] xn;
        logic [7:0] yn;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mem_n[i] = '0;
            mem_w[i] = '0;
        end
        exp2_x = '0; exp2_y = '0;
        exp3_x = '0; exp3_y = '0;
    endtask

    // Read rule: zero entry, then port B bypass, then port A, then storage.
    function automatic logic [15:0] ref_rd(input bit wide, input bit byp,
                                           input int a);
        if (a == 0) return 16'h0;
        if (wide) begin
            if (byp && w_wenb && int'(w_rb) == a) return w_db;
            if (byp && w_wena && int'(w_ra) == a) return w_da;
            return mem_w[a];
        end
        if (byp && n_wenb && int'(n_rb) == a) return {8'h0, n_db};
        if (byp && n_wena && int'(n_ra) == a) return {8'h0, n_da};
        return mem_n[a];
    endfunction

    task automatic drive_n(input logic wa, input logic [2:0] ra,
                           input logic [7:0] da, input logic wb,
                           input logic [2:0] rb, input logic [7:0] db,
                           input logic [2:0] rx, input logic [2:0] ry);
        n_wena = wa; n_ra = ra; n_da = da;
        n_wenb = wb; n_rb = rb; n_db = db;
        n_rx = rx; n_ry = ry;
    endtask

    task automatic drive_w(input logic wa, input logic [3:0] ra,
                           input logic [15:0] da, input logic wb,
                           input logic [3:0] rb, input logic [15:0] db,
                           input logic [3:0] rx, input logic [3:0] ry);
        w_wena = wa; w_ra = ra; w_da = da;
        w_wenb = wb; w_rb = rb; w_db = db;
        w_rx = rx; w_ry = ry;
    endtask

    task automatic pre_check();
        chk("u0_x", {8'h0, n0_x}, ref_rd(0, 1, int'(n_rx)));
        chk("u0_y", {8'h0, n0_y}, ref_rd(0, 1, int'(n_ry)));
        chk("u1_x", {8'h0, n1_x}, ref_rd(0, 0, int'(n_rx)));
        chk("u1_y", {8'h0, n1_y}, ref_rd(0, 0, int'(n_ry)));
        exp2_x = ref_rd(1, 0, int'(w_rx));
        exp2_y = ref_rd(1, 0, int'(w_ry));
        exp3_x = ref_rd(1, 1, int'(w_rx));
        exp3_y = ref_rd(1, 1, int'(w_ry));
    endtask

    task automatic post_edge();
        if (n_wena && n_ra != 0) mem_n[n_ra] = {8'h0, n_da};
        if (n_wenb && n_rb != 0) mem_n[n_rb] = {8'h0, n_db};
        if (w_wena && w_ra != 0) mem_w[w_ra] = w_da;
        if (w_wenb && w_rb != 0) mem_w[w_rb] = w_db;
        @(posedge Clk);
        #1;
        chk("u2_x", w2_x, exp2_x);
        chk("u2_y", w2_y, exp2_y);
        chk("u3_x", w3_x, exp3_x);
        chk("u3_y", w3_y, exp3_y);
    endtask

    task automatic all_zero(input string nm);
        chk({nm, "_u0x"}, {8'h0, n0_x}, 16'h0);
        chk({nm, "_u0y"}, {8'h0, n0_y}, 16'h0);
        chk({nm, "_u1x"}, {8'h0, n1_x}, 16'h0);
        chk({nm, "_u1y"}, {8'h0, n1_y}, 16'h0);
        chk({nm, "_u2x"}, w2_x, 16'h0);
        chk({nm, "_u2y"}, w2_y, 16'h0);
        chk({nm, "_u3x"}, w3_x, 16'h0);
        chk({nm, "_u3y"}, w3_y, 16'h0);
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            drive_n(1'($urandom), 3'($urandom), 8'($urandom),
                    1'($urandom), 3'($urandom), 8'($urandom),
                    3'($urandom), 3'($urandom));
            drive_w(1'($urandom), 4'($urandom), 16'($urandom),
                    1'($urandom), 4'($urandom), 16'($urandom),
                    4'($urandom), 4'($urandom));
            #10;
            pre_check();
            post_edge();
        end
    endtask

    initial begin
        tbl[0] = '{1, 3, 8'h5a, 0, 0, 8'h00, 3, 0, 8'h5a, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{0, 0, 8'h00, 0, 0, 8'h00, 3, 3, 8'h5a, 8'h5a, 8'h5a, 8'h5a};
        tbl[2] = '{1, 0, 8'hff, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3] = '{1, 5, 8'h11, 1, 5, 8'h22, 5, 5, 8'h22, 8'h22, 8'h00, 8'h00};
        tbl[4] = '{0, 0, 8'h00, 0, 0, 8'h00, 5, 0, 8'h22, 8'h00, 8'h22, 8'h00};
        tbl[5] = '{1, 2, 8'h10, 0, 0, 8'h00, 2, 0, 8'h10, 8'h00, 8'h00, 8'h00};
        tbl[6] = '{1, 2, 8'h77, 0, 0, 8'h00, 2, 2, 8'h77, 8'h77, 8'h10, 8'h10};
        tbl[7] = '{0, 0, 8'h00, 0, 0, 8'h00, 2, 5, 8'h77, 8'h22, 8'h77, 8'h22};
        tbl[8] = '{1, 2, 8'haa, 1, 2, 8'h99, 2, 3, 8'h99, 8'h5a, 8'h77, 8'h5a};
        tbl[9] = '{0, 0, 8'h00, 0, 0, 8'h00, 2, 0, 8'h99, 8'h00, 8'h99, 8'h00};

        Rst_n = 1'b0;
        drive_n(0, 0, 0, 0, 0, 0, 0, 0);
        drive_w(0, 0, 0, 0, 0, 0, 0, 0);
        clear_model();
        repeat (2) @(posedge Clk);
        #1;
        all_zero("rst_init");
        #9;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive_n(tbl[i].wa, tbl[i].ra, tbl[i].da, tbl[i].wb,
                    tbl[i].rb, tbl[i].db, tbl[i].rx, tbl[i].ry);
            drive_w(0, 0, 0, 0, 0, 0, 4'($urandom), 4'($urandom));
            #10;
            chk($sformatf("tbl%0d_u0x", i), {8'h0, n0_x}, {8'h0, tbl[i].xb});
            chk($sformatf("tbl%0d_u0y", i), {8'h0, n0_y}, {8'h0, tbl[i].yb});
            chk($sformatf("tbl%0d_u1x", i), {8'h0, n1_x}, {8'h0, tbl[i].xn});
            chk($sformatf("tbl%0d_u1y", i), {8'h0, n1_y}, {8'h0, tbl[i].yn});
            pre_check();
            post_edge();
        end

        rand_cycles(300);

        // Asynchronous clear with no clock edge, then writes held off.
        Rst_n = 1'b0;
        drive_n(0, 0, 0, 0, 0, 0, 0, 0);
        drive_w(0, 0, 0, 0, 0, 0, 0, 0);
        clear_model();
        #1;
        for (int a = 0; a < 16; a++) begin
            n_rx = 3'(a); n_ry = 3'(7 - (a % 8));
            w_rx = 4'(a); w_ry = 4'(15 - a);
            #1;
            all_zero($sformatf("rst_a%0d", a));
        end
        drive_n(1, 3, 8'hff, 1, 4, 8'hee, 3, 4);
        drive_w(1, 15, 16'hffff, 1, 9, 16'heeee, 15, 9);
        @(posedge Clk);
        #1;
        n_wena = 0; n_wenb = 0;
        w_wena = 0; w_wenb = 0;
        #1;
        all_zero("rst_wr");
        #5;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        drive_n(0, 0, 0, 0, 0, 0, 0, 0);
        drive_w(1, 15, 16'hbeef, 0, 0, 0, 0, 15);
        #10; pre_check(); post_edge();
        chk("seq1_u2y", w2_y, 16'h0000);
        chk("seq1_u3y", w3_y, 16'hbeef);
        drive_w(0, 0, 0, 0, 0, 0, 0, 15);
        #10; pre_check(); post_edge();
        chk("seq2_u2y", w2_y, 16'hbeef);
        drive_w(1, 14, 16'h1234, 1, 15, 16'h5678, 14, 15);
        #10; pre_check(); post_edge();
        chk("seq3_u3x", w3_x, 16'h1234);
        chk("seq3_u3y", w3_y, 16'h5678);
        chk("seq3_u2x", w2_x, 16'h0000);
        chk("seq3_u2y", w2_y, 16'hbeef);
        drive_w(0, 0, 0, 0, 0, 0, 14, 15);
        #10; pre_check(); post_edge();
        chk("seq4_u2x", w2_x, 16'h1234);
        chk("seq4_u2y", w2_y, 16'h5678);

        rand_cycles(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
